// File: rtl/serial_link_arbiter.sv
// Round-robin arbiter + MSB-first serializer sharing one serial line between two requesters.
// Optional trailing even-parity bit per frame: define SERIAL_LINK_PARITY_EN.
module serial_link_arbiter #(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             sout,
    output logic             sframe,
    output logic             grant_id,
    output logic             busy
);

    // Handshake: a word transfers on a rising edge where valid && ready; ready is only
    // offered in IDLE to the arbitration winner, so at most one ready is high at a time.

    localparam int CNT_MAX = (WIDTH - 1 > GAP_CYCLES) ? WIDTH - 1 : GAP_CYCLES;
    localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SHIFT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

`ifdef SERIAL_LINK_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

    localparam state_t AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             grant_q;
    logic             last_q;
    logic             winner;
    logic             accept;
    logic             last_bit;
`ifdef SERIAL_LINK_PARITY_EN
    logic             par_q;
`endif

    // last_q holds the most recent grant; resetting it to 1 makes req0 win the first tie.
    assign winner     = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign req0_ready = (state == IDLE) && !winner && clear;
    assign req1_ready = (state == IDLE) && winner && clear;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign last_bit   = (cnt == '0);
    assign busy       = (state != IDLE);
    assign grant_id   = grant_q;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = SHIFT;
`ifdef SERIAL_LINK_PARITY_EN
            SHIFT:  if (last_bit) state_next = PARITY;
            PARITY: state_next = AFTER_FRAME;
`else
            SHIFT:  if (last_bit) state_next = AFTER_FRAME;
`endif
            GAP:   if (last_bit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            shreg   <= '0;
            cnt     <= '0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
`ifdef SERIAL_LINK_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg   <= winner ? req1_data : req0_data;
                        cnt     <= SHIFT_LOAD;
                        grant_q <= winner;
                        last_q  <= winner;
`ifdef SERIAL_LINK_PARITY_EN
                        par_q   <= winner ? ^req1_data : ^req0_data;
`endif
                    end
                end
                SHIFT: begin
                    // The gap count is preloaded on the last bit; a parity cycle leaves it untouched.
                    if (last_bit) begin
                        cnt <= GAP_LOAD;
                    end else begin
                        shreg <= {shreg[WIDTH-2:0], 1'b0};
                        cnt   <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (!last_bit) cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sout   = 1'b0;
        sframe = 1'b0;
        case (state)
            SHIFT: begin
                sout   = shreg[WIDTH-1];
                sframe = 1'b1;
            end
`ifdef SERIAL_LINK_PARITY_EN
            PARITY: begin
                sout   = par_q;
                sframe = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: doc/serial_link_arbiter.md
# serial_link_arbiter

Round-robin arbiter and serializer that shares one serial line between two parallel-word requesters. Each granted word is shifted out MSB-first on `sout`, one bit per clock, with a frame strobe. `sout` drives the serial input of the downstream serial-in/serial-out shift-register chain. The block owns all sequencing of that chain: arbitration, load, shift count and inter-frame gap.

## Interface

Parameters:
- `WIDTH`, 4: bits per word; legal range 2..16.
- `GAP_CYCLES`, 1: idle cycles forced after each frame; legal range 0..15.

Ports:
- `clk`  in  1  rising-edge clock.
- `clear`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has a word.
- `req0_data`  in  WIDTH  requester 0 word.
- `req0_ready`  out  1  requester 0 word accepted this edge if valid.
- `req1_valid`  in  1  requester 1 has a word.
- `req1_data`  in  WIDTH  requester 1 word.
- `req1_ready`  out  1  requester 1 word accepted this edge if valid.
- `sout`  out  1  serial data to the shift-register chain input.
- `sframe`  out  1  high while `sout` carries a frame bit.
- `grant_id`  out  1  owner of the current or last frame.
- `busy`  out  1  high in any state other than IDLE.

## Operation

- FSM states and transitions:
  - IDLE → SHIFT on an accept.
  - SHIFT → GAP after the last bit.
  - GAP → IDLE after `GAP_CYCLES` cycles.
  - When `GAP_CYCLES`=0, SHIFT goes straight to IDLE.
- Arbitration in IDLE:
  - Only one valid: that requester wins.
  - Both valid: the requester not granted last wins.
  - Priority pointer resets to favour req0.
- Ready signals:
  - `reqN_ready` is combinational: (state==IDLE) && winner==N && `clear` high.
  - At most one ready is ever high.
- Accept = valid && ready at a rising edge. On accept:
  - Winner's data is loaded into the internal shift register.
  - `grant_id` is set to the winner.
  - The bit counter is loaded with WIDTH-1.
  - The priority pointer is updated.
- SHIFT:
  - `sout` = shift-register MSB and `sframe`=1.
  - The register shifts left by one each cycle and the counter decrements.
  - The last bit is sent in the cycle the counter is 0.
- Requester inputs are ignored outside the accept edge. A changed or dropped valid during SHIFT or GAP has no effect.
- Requesters hold `valid` and `data` stable until ready. Dropping valid before accept withdraws the request without error.
- Outside SHIFT (and PARITY when enabled): `sout`=0 and `sframe`=0.
- `grant_id` holds its value between frames.
- Reset values: `sout`=0, `sframe`=0, `busy`=0, `grant_id`=0, both readies 0, state IDLE, pointer favours req0.
- Reset asserted mid-frame:
  - All outputs reach their reset values immediately (asynchronously).
  - The frame is abandoned and not resumed.
- The counter width is enough to hold max(WIDTH-1, GAP_CYCLES). It never wraps below 0.

## Timing

- Accept at edge k:
  - `sout`/`sframe` carry bit WIDTH-1 in the cycle after edge k.
  - Bit 0 is carried in the cycle after edge k+WIDTH-1.
- `busy` rises in the cycle after edge k.
- IDLE always lasts at least one cycle. Minimum accept-to-accept spacing is WIDTH+GAP_CYCLES+1 edges (6 at defaults).
- Ready is visible in the same cycle the FSM enters IDLE. A request held valid is accepted at the first edge of IDLE.

## Configuration

- `SERIAL_LINK_PARITY_EN` defined:
  - A PARITY state follows SHIFT for one cycle.
  - In that cycle `sout` = even parity (XOR of all WIDTH data bits) and `sframe`=1.
  - Minimum accept spacing becomes WIDTH+GAP_CYCLES+2.
- Macro undefined:
  - No PARITY state, no parity logic.
  - Frames are exactly WIDTH bits.

## Test plan

All scenarios use WIDTH=4, GAP_CYCLES=1.

- Single word: reset, release `clear`, req0_valid=1 with data 4'b1010.
  - Accepted at the first edge.
  - `sout` = 1,0,1,0 on four consecutive cycles with `sframe`=1; `grant_id`=0.
  - Then `sframe`=0 and `busy` falls after the one-cycle gap.
- Contention: both valid from reset, req0=4'b1010, req1=4'b0101.
  - req0 is served first (1,0,1,0).
  - req1 is accepted 6 edges later and sends 0,1,0,1 with `grant_id`=1.
  - Fairness: with both held continuously, grants alternate 0,1,0,1 over 4 frames.
- Mid-frame reset: assert `clear` low after the 2nd bit of 4'b1100.
  - `sout`, `sframe`, `busy`, `grant_id` are 0 immediately.
  - After release, the held request restarts from bit 3.
- Data disturbance: change req0_data to 4'b0000 during SHIFT of 4'b1001.
  - `sout` still sends 1,0,0,1.
  - Ready stays 0 throughout SHIFT and GAP.
- Parity, with `SERIAL_LINK_PARITY_EN`: send 4'b1011.
  - `sout` = 1,0,1,1,1 with `sframe` high for 5 cycles.
  - Accept spacing is 7 edges.
